morse_char_assembler: RTL
=========================

# morse_char_assembler

Assembles the single-cycle `dot`, `dash`, `lg` (letter gap) and `wg` (word gap) pulses from the Morse keying controller into 8-bit uppercase ASCII characters. Characters are buffered in a small FIFO with a valid/ready output interface. The block sits directly downstream of the keying FSM and upstream of the display/UART character sink. It decodes international Morse letters A–Z and digits 0–9, maps a word gap to a space, and flags malformed or over-long symbols.

## Interface
- `DEPTH`, 8: FIFO depth in characters. Must be a power of 2, ≥2.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `dot` input 1: single-cycle pulse; append dot to the current letter.
- `dash` input 1: single-cycle pulse; append dash to the current letter.
- `lg` input 1: single-cycle pulse; letter complete, decode and push.
- `wg` input 1: single-cycle pulse; word complete, flush any pending letter, then push a space.
- `clear` input 1: synchronous clear of the FIFO, symbol register and flags.
- `char_data` output 8: ASCII character at the FIFO head; valid only while `char_valid` is high.
- `char_valid` output 1: FIFO not empty.
- `char_ready` input 1: sink accepts `char_data` this cycle.
- `fifo_full` output 1: FIFO holds `DEPTH` entries.
- `overflow` output 1: sticky; a push was dropped because the FIFO was full.
- `sym_err` output 1: sticky; an undecodable, over-long or dot+dash-collision letter was emitted as `?`.

## Operation
- **Symbol register**
  - `code[4:0]` plus `len[2:0]`, range 0–5.
  - Dot shifts in 0; dash shifts in 1. `code` is LSB-aligned and MSB-first in time. Example: A (.-) gives len=2, code=00001.
  - `dot` and `dash` high in the same cycle: append a dash and set the internal `bad` bit.
  - Symbol received while len=5: `len`/`code` are unchanged and `bad` is set.
- **Decode**
  - Combinational lookup on (len, code, bad) per ITU-R M.1677 for A–Z (0x41–0x5A) and 0–9 (0x30–0x39).
  - Any other combination, or `bad`=1, gives 0x3F (`?`) and sets `sym_err`.
  - Examples: E (len1, 0) → 0x45. T (len1, 1) → 0x54. S (len3, 000) → 0x53. 0 (len5, 11111) → 0x30. 5 (len5, 00000) → 0x35.
- **Same-cycle symbol and gap**
  - A symbol pulse in the same cycle as `lg`/`wg` is appended before decode.
  - The decode input is therefore the next-state symbol register.
- **Emit control FSM**
  - States: COLLECT (reset) and SPACE_PEND.
  - COLLECT, `lg`, effective len>0: push the decoded char, then clear len/code/bad. Stay in COLLECT.
  - COLLECT, `lg`, len=0: no push, no state change.
  - COLLECT, `wg`, effective len>0: push the decoded char, clear the symbol register, go to SPACE_PEND.
  - COLLECT, `wg`, len=0: push 0x20, stay in COLLECT.
  - `lg` and `wg` in the same cycle: treated as `wg`.
  - SPACE_PEND: push 0x20 unconditionally, return to COLLECT.
    - Symbol pulses in this cycle are still captured into the cleared register.
    - `lg`/`wg` in this cycle are ignored.
- **FIFO**
  - Circular buffer of `DEPTH`×8 with log2(`DEPTH`)-bit read/write pointers that wrap.
  - Count register is log2(`DEPTH`)+1 bits.
  - Pop happens when `char_valid & char_ready`.
  - Push while full with no simultaneous pop: the char is dropped and `overflow` is set. Pointers and count are unchanged.
  - Push and pop in the same cycle while full: both are accepted, count is unchanged.
  - Push and pop in the same cycle while non-empty and not full: both are accepted.
  - Empty: no bypass. A pushed char appears the next cycle.
- **`clear`**
  - Empties the FIFO, zeroes len/code/bad, returns the FSM to COLLECT, and clears both sticky flags.
  - `clear` has priority over all other inputs in the same cycle.

## Timing
- **Reset values:** `char_data`=0x00, `char_valid`=0, `fifo_full`=0, `overflow`=0, `sym_err`=0, FSM=COLLECT, len=0, code=0, pointers=0.
- **Latency:** `lg` in cycle N → `char_valid`=1 with the char in cycle N+1 (FIFO previously empty).
- **Word gap:** `wg` in cycle N with a letter pending → letter pushed at the end of N, space pushed at the end of N+1.
- **Head output:** `char_data` is a registered or RAM-read value of the head entry and is stable while `char_valid` is high and `char_ready` is low.
- **Reset mid-operation:** asynchronous and immediate. Partial letters and FIFO contents are lost, with no spurious push after release.
- **Upstream throughput:** sustains one push per cycle. The minimum upstream pulse spacing is 2 cycles, so SPACE_PEND never collides with a pending letter push.

## Test plan
- **Single letter:** after reset, pulse dot, dash, then lg with `char_ready`=1 → one beat with `char_data`=0x41, then `char_valid` drops.
- **Word flush:** key "SOS" (... --- ... with lg between letters), then `wg` on the last letter instead of lg → FIFO emits 0x53, 0x4F, 0x53, 0x20 in order; `sym_err`=0.
- **Over-long symbol:** six dots then lg → emits 0x3F and sets `sym_err`. Then `-----` + lg → emits 0x30 (the register was cleared between letters).
- **Collision and same-cycle:** dot and dash asserted together then lg → 0x3F, `sym_err`=1. In a separate case, dash in the same cycle as lg with the register empty → 0x54.
- **FIFO full:** with `char_ready`=0, push 9 E's (`DEPTH`=8) → `fifo_full`=1 after the 8th, `overflow`=1 after the 9th. Drain with `char_ready`=1 → exactly 8 × 0x45.
- **Reset and clear:** assert `reset_n`=0 while in SPACE_PEND with 3 chars buffered → all outputs at reset values, no 0x20 emitted after release. Repeat using `clear` → the same result on the next edge, with sticky flags cleared.

Source files
------------

// File: rtl/morse_char_assembler.sv
// Morse keying pulses to ASCII: a 5-bit symbol register, a table decoder and a
// two-state emit FSM feeding a circular character FIFO with a valid/ready head.
module morse_char_assembler #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_i,
  input  logic       dash_i,
  input  logic       lg_i,
  input  logic       wg_i,
  input  logic       clear_i,
  output logic [7:0] char_data_o,
  output logic       char_valid_o,
  input  logic       char_ready_i,
  output logic       fifo_full_o,
  output logic       overflow_o,
  output logic       sym_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {StCollect, StSpacePend} state_e;

  state_e            state_q, state_d;
  logic [2:0]        len_q, len_d, len_eff;
  logic [4:0]        code_q, code_d, code_eff;
  logic              bad_q, bad_d, bad_eff;
  logic [7:0]        dec_char;
  logic              push, dec_push, sym_flush;
  logic [7:0]        push_char;
  logic [7:0]        mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d, sym_err_q, sym_err_d;
  logic              full, pop, wr_en;

  // Effective symbol: the register with this cycle's pulse already appended.
  always_comb begin
    len_eff  = len_q;
    code_eff = code_q;
    bad_eff  = bad_q;
    if (dot_i | dash_i) begin
      if (len_q == 3'd5) begin
        bad_eff = 1'b1;
      end else begin
        code_eff = {code_q[3:0], dash_i};
        len_eff  = len_q + 3'd1;
      end
      if (dot_i & dash_i) bad_eff = 1'b1;
    end
  end

  always_comb begin
    dec_char = 8'h3F;
    case ({len_eff, code_eff})
      {3'd1, 5'b00000}: dec_char = 8'h45; // E
      {3'd1, 5'b00001}: dec_char = 8'h54; // T
      {3'd2, 5'b00000}: dec_char = 8'h49; // I
      {3'd2, 5'b00001}: dec_char = 8'h41; // A
      {3'd2, 5'b00010}: dec_char = 8'h4E; // N
      {3'd2, 5'b00011}: dec_char = 8'h4D; // M
      {3'd3, 5'b00000}: dec_char = 8'h53; // S
      {3'd3, 5'b00001}: dec_char = 8'h55; // U
      {3'd3, 5'b00010}: dec_char = 8'h52; // R
      {3'd3, 5'b00011}: dec_char = 8'h57; // W
      {3'd3, 5'b00100}: dec_char = 8'h44; // D
      {3'd3, 5'b00101}: dec_char = 8'h4B; // K
      {3'd3, 5'b00110}: dec_char = 8'h47; // G
      {3'd3, 5'b00111}: dec_char = 8'h4F; // O
      {3'd4, 5'b00000}: dec_char = 8'h48; // H
      {3'd4, 5'b00001}: dec_char = 8'h56; // V
      {3'd4, 5'b00010}: dec_char = 8'h46; // F
      {3'd4, 5'b00100}: dec_char = 8'h4C; // L
      {3'd4, 5'b00110}: dec_char = 8'h50; // P
      {3'd4, 5'b00111}: dec_char = 8'h4A; // J
      {3'd4, 5'b01000}: dec_char = 8'h42; // B
      {3'd4, 5'b01001}: dec_char = 8'h58; // X
      {3'd4, 5'b01010}: dec_char = 8'h43; // C
      {3'd4, 5'b01011}: dec_char = 8'h59; // Y
      {3'd4, 5'b01100}: dec_char = 8'h5A; // Z
      {3'd4, 5'b01101}: dec_char = 8'h51; // Q
      {3'd5, 5'b01111}: dec_char = 8'h31;
      {3'd5, 5'b00111}: dec_char = 8'h32;
      {3'd5, 5'b00011}: dec_char = 8'h33;
      {3'd5, 5'b00001}: dec_char = 8'h34;
      {3'd5, 5'b00000}: dec_char = 8'h35;
      {3'd5, 5'b10000}: dec_char = 8'h36;
      {3'd5, 5'b11000}: dec_char = 8'h37;
      {3'd5, 5'b11100}: dec_char = 8'h38;
      {3'd5, 5'b11110}: dec_char = 8'h39;
      {3'd5, 5'b11111}: dec_char = 8'h30;
      default:          dec_char = 8'h3F;
    endcase
    if (bad_eff) dec_char = 8'h3F;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StCollect;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect:   if (wg_i && len_eff != 3'd0) state_d = StSpacePend;
      StSpacePend: state_d = StCollect;
      default:     state_d = StCollect;
    endcase
    if (clear_i) state_d = StCollect;
  end

  always_comb begin
    push      = 1'b0;
    push_char = 8'h20;
    dec_push  = 1'b0;
    sym_flush = 1'b0;
    unique case (state_q)
      StCollect: begin
        if ((lg_i | wg_i) && len_eff != 3'd0) begin
          push      = 1'b1;
          push_char = dec_char;
          dec_push  = 1'b1;
          sym_flush = 1'b1;
        end else if (wg_i) begin
          push = 1'b1;
        end
      end
      StSpacePend: push = 1'b1;
      default: ;
    endcase
  end

  assign full  = count_q[AW];
  assign pop   = char_valid_o & char_ready_i;
  assign wr_en = push & ~clear_i & (~full | pop);

  always_comb begin
    len_d      = len_eff;
    code_d     = code_eff;
    bad_d      = bad_eff;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    sym_err_d  = sym_err_q | (dec_push & (dec_char == 8'h3F));
    if (sym_flush) begin
      len_d  = 3'd0;
      code_d = 5'd0;
      bad_d  = 1'b0;
    end
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (pop)   rptr_d = rptr_q + AW'(1);
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    if (clear_i) begin
      len_d      = 3'd0;
      code_d     = 5'd0;
      bad_d      = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      sym_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= 3'd0;
      code_q     <= 5'd0;
      bad_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sym_err_q  <= 1'b0;
    end else begin
      len_q      <= len_d;
      code_q     <= code_d;
      bad_q      <= bad_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sym_err_q  <= sym_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_char;
  end

  assign char_valid_o = (count_q != '0);
  // Gate the head so stale RAM contents never show while empty.
  assign char_data_o  = char_valid_o ? mem_q[rptr_q] : 8'h00;
  assign fifo_full_o  = full;
  assign overflow_o   = overflow_q;
  assign sym_err_o    = sym_err_q;

endmodule
